result_writeback: RTL and testbench

RESULT_WRITEBACK -- requirements
Module: result_writeback

---
 rtl/result_writeback_pkg.sv | 14 +
 rtl/result_writeback_if.sv | 14 +
 rtl/pixel_quantize.sv | 27 ++
 rtl/result_writeback.sv | 140 ++++++++++++++
 tb/tb_result_writeback.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/result_writeback_pkg.sv
// rtl/result_writeback_pkg.sv - shared NPU constants and writeback FSM encoding
package result_writeback_pkg;

  localparam int NPU_N      = 10;
  localparam int NPU_SHIFT  = 8;
  localparam int NPU_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/result_writeback_if.sv
// rtl/result_writeback_if.sv - pixel write bus between writeback engine and memory
interface result_writeback_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_ready;

  modport master (output mem_addr, output mem_wdata, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_ready);

endinterface

// File: rtl/pixel_quantize.sv
// rtl/pixel_quantize.sv - round-half-up, arithmetic shift and clamp of a signed result to a pixel
module pixel_quantize #(
  parameter int SHIFT = 8
) (
  input  logic [15:0] din,
  output logic [7:0]  dout
);

  // 17 bits hold 32767 + 2^14 without overflow for any legal SHIFT
  localparam logic signed [16:0] RND = 17'sd1 <<< (SHIFT - 1);

  logic signed [16:0] v;
  logic signed [16:0] s;

  always_comb begin
    v = $signed({din[15], din}) + RND;
    s = v >>> SHIFT;
    if (s < 17'sd0) begin
      dout = 8'd0;
    end else if (s > 17'sd255) begin
      dout = 8'hFF;
    end else begin
      dout = s[7:0];
    end
  end

endmodule

// File: rtl/result_writeback.sv
// rtl/result_writeback.sv - snapshots an N x N result tile and writes it row-major as quantized pixels
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int N      = NPU_N,
  parameter int SHIFT  = NPU_SHIFT,
  parameter int ADDR_W = NPU_ADDR_W,
  parameter int STRIDE = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N-1:0][N-1:0][15:0] A_result,
  input  logic [ADDR_W-1:0]         base_addr,
  result_writeback_if.master        mem,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]     LAST     = CW'(N - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  wb_state_e                 state_q, state_d;
  logic [CW-1:0]             r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0]         row_base_q, row_base_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [7:0]                wdata_q, wdata_d;
  logic                      we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [N-1:0][N-1:0][15:0] snap_q, snap_d;

  logic [CW-1:0] nr, nc;
  logic [15:0]   q_in;
  logic [7:0]    q_out;
  logic          accept;

  pixel_quantize #(.SHIFT(SHIFT)) u_quant (
    .din  (q_in),
    .dout (q_out)
  );

  // The quantizer always looks one element ahead so the output registers can load on acceptance
  always_comb begin
    accept = we_q & mem.mem_ready;
    nr     = r_q;
    nc     = c_q + CW'(1);
    if (c_q == LAST) begin
      nc = '0;
      nr = (r_q == LAST) ? '0 : r_q + CW'(1);
    end
    q_in = (state_q == ST_IDLE) ? A_result[0][0] : snap_q[nr][nc];
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    snap_d     = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d     = A_result;
          r_d        = '0;
          c_d        = '0;
          row_base_d = base_addr;
          addr_d     = base_addr;
          wdata_d    = q_out;
          we_d       = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          if (r_q == LAST && c_q == LAST) begin
            state_d = ST_DONE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            r_d     = '0;
            c_d     = '0;
          end else begin
            r_d     = nr;
            c_d     = nc;
            wdata_d = q_out;
            if (c_q == LAST) begin
              row_base_d = row_base_q + STRIDE_A;
              addr_d     = row_base_q + STRIDE_A;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_result_writeback.sv
// tb/tb_result_writeback.sv - randomized scenario bench for result_writeback against a tile model
module tb_result_writeback;

  localparam int N  = 10;
  localparam int NN = N * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, start, sel, mem_ready;
  logic [N-1:0][N-1:0][15:0] a_result;
  logic [15:0]               base_addr;
  logic                      busy_a, done_a, busy_b, done_b;

  result_writeback_if #(.ADDR_W(16)) ifa ();
  result_writeback_if #(.ADDR_W(16)) ifb ();

  wire start_a = start & ~sel;
  wire start_b = start & sel;
  assign ifa.mem_ready = mem_ready;
  assign ifb.mem_ready = mem_ready;

  result_writeback #(.N(N), .SHIFT(8), .ADDR_W(16), .STRIDE(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .A_result(a_result), .base_addr(base_addr),
    .mem(ifa), .busy(busy_a), .done(done_a)
  );

  result_writeback #(.N(N), .SHIFT(1), .ADDR_W(16), .STRIDE(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .A_result(a_result), .base_addr(base_addr),
    .mem(ifb), .busy(busy_b), .done(done_b)
  );

  wire        obs_we   = sel ? ifb.mem_we    : ifa.mem_we;
  wire [15:0] obs_addr = sel ? ifb.mem_addr  : ifa.mem_addr;
  wire [7:0]  obs_data = sel ? ifb.mem_wdata : ifa.mem_wdata;
  wire        obs_busy = sel ? busy_b : busy_a;
  wire        obs_done = sel ? done_b : done_a;

  int vectors;
  int miscompares;
  int tile_m [N][N];

  function automatic int quant(input int x, input int sh);
    int v;
    v = (x + (1 << (sh - 1))) >>> sh;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        a_result[r][c] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70000) - 2000);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic run_tile(input string tag, input int mode, input int base, input int rst_at, input int mid_at);
    int acc, cyc, rdy, r, c, stride, sh, ea, ed;
    bit finished;
    stride = sel ? 16 : 10;
    sh     = sel ? 1 : 8;
    @(negedge clk);
    base_addr = 16'(base);
    start     = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        tile_m[i][j] = $signed(a_result[i][j]);
    @(negedge clk);
    start    = 1'b0;
    acc      = 0;
    cyc      = 1;
    finished = 1'b0;
    while (cyc <= 2000) begin
      if (acc == NN) begin
        vectors++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_we !== 1'b0) begin
          miscompares++;
          $display("FAIL %s done_cycle done=%b busy=%b we=%b exp 1/0/0", tag, obs_done, obs_busy, obs_we);
        end
        if (mode == 0) begin
          vectors++;
          if (cyc != NN + 1) begin
            miscompares++;
            $display("FAIL %s done_latency got=%0d exp=%0d", tag, cyc, NN + 1);
          end
        end
        finished = 1'b1;
        break;
      end
      if (rst_at > 0 && acc == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs_we !== 1'b0 || obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_addr !== 16'h0 || obs_data !== 8'h0) begin
          miscompares++;
          $display("FAIL %s after_rst we=%b done=%b busy=%b addr=%h data=%h exp all 0", tag, obs_we, obs_done, obs_busy, obs_addr, obs_data);
        end
        rst = 1'b0;
        repeat (NN + 5) begin
          @(negedge clk);
          vectors++;
          if (obs_we !== 1'b0 || obs_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s abandoned we=%b done=%b exp 0/0", tag, obs_we, obs_done);
          end
        end
        finished = 1'b1;
        break;
      end
      vectors++;
      if (obs_we !== 1'b1 || obs_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s we_busy idx=%0d we=%b busy=%b exp 1/1", tag, acc, obs_we, obs_busy);
      end
      r  = acc / N;
      c  = acc % N;
      ea = (base + r * stride + c) & 16'hFFFF;
      ed = quant(tile_m[r][c], sh);
      vectors++;
      if (obs_addr !== 16'(ea) || obs_data !== 8'(ed)) begin
        miscompares++;
        $display("FAIL %s write idx=%0d addr=%h data=%0d exp addr=%h data=%0d", tag, acc, obs_addr, obs_data, ea, ed);
      end
      if (mid_at > 0) begin
        if (cyc == mid_at) begin
          fill_random();
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      case (mode)
        0:       rdy = 1;
        1:       rdy = ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3) ? 1 : 0;
        default: rdy = int'($urandom_range(0, 1));
      endcase
      mem_ready = rdy[0];
      if (obs_we === 1'b1 && rdy == 1) acc++;
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout accepted=%0d exp %0d", tag, acc, NN);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sel = 1'b0; mem_ready = 1'b1; base_addr = '0;
    fill_random();
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_we !== 1'b0 || obs_addr !== 16'h0 || obs_data !== 8'h0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset we=%b addr=%h data=%h busy=%b done=%b exp all 0", obs_we, obs_addr, obs_data, obs_busy, obs_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_tile();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        a_result[r][c] = 16'd256;
    run_tile("full_tile", 0, 16'h0100, 0, 0);
    @(negedge clk);
    vectors++;
    if (obs_done !== 1'b0 || obs_we !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width done=%b we=%b exp 0/0", obs_done, obs_we);
    end
  endtask

  task automatic test_quant_points();
    fill_random();
    a_result[0][0] = 16'hFED4;
    a_result[0][1] = 16'd127;
    a_result[0][2] = 16'd128;
    a_result[0][3] = 16'h7FFF;
    run_tile("quant_points", 0, int'($urandom_range(0, 65535)), 0, 0);
  endtask

  task automatic test_stall();
    fill_random();
    run_tile("stall_1001", 1, 16'h2000, 0, 0);
  endtask

  task automatic test_random_ready();
    repeat (2) begin
      fill_random();
      run_tile("random_ready", 2, int'($urandom_range(0, 65535)), 0, 0);
    end
  endtask

  task automatic test_wrap_clamp();
    sel = 1'b1;
    fill_random();
    a_result[0][0] = 16'h7FFF;
    run_tile("wrap_clamp", 0, 16'hFFFA, 0, 0);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_tile();
    fill_random();
    run_tile("reset_mid", 0, 16'h0400, 37, 0);
    fill_random();
    run_tile("after_reset", 2, 16'h0500, 0, 0);
  endtask

  task automatic test_mid_start();
    fill_random();
    run_tile("mid_start", 0, 16'h0600, 0, 20);
  endtask

  task automatic test_done_start();
    fill_random();
    run_tile("pre_done_start", 0, 16'h0700, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      vectors++;
      if (obs_we !== 1'b0 || obs_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL start_in_done we=%b busy=%b exp 0/0", obs_we, obs_busy);
      end
      @(negedge clk);
    end
    fill_random();
    run_tile("idle_start", 0, 16'h0800, 0, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_full_tile();
    test_quant_points();
    test_stall();
    test_random_ready();
    test_wrap_clamp();
    test_reset_mid_tile();
    test_mid_start();
    test_done_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
